// File: rtl/seq_1011_pkg.sv
// Shared definitions for the "1011" frame line: state encoding, preamble and
// the history pattern that forces a stuff bit.
package seq_1011_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } tx_state_t;

  localparam logic [3:0] PREAMBLE      = 4'b1011;
  // If the last three line bits are 1,0,1 a following 1 would recreate the
  // preamble, so a 0 is inserted instead.
  localparam logic [2:0] STUFF_TRIGGER = 3'b101;

  // Shift a newly sent line bit into the history (bit 0 is the newest).
  function automatic logic [2:0] hist_push(input logic [2:0] hist, input logic line_bit);
    return {hist[1:0], line_bit};
  endfunction

endpackage

// File: rtl/seq_bit_timer.sv
// Bit-period prescaler: while enabled, counts 0..DIV-1 and pulses bit_tick on
// the last count so each line bit is held DIV cycles.
module seq_bit_timer #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  output logic bit_tick
);

  localparam int              CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]   LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_reg;

  // Period counter; held at zero while disabled so each frame starts aligned.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_reg <= '0;
    end else if (!en || (cnt_reg == LAST)) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign bit_tick = en && (cnt_reg == LAST);

endmodule

// File: rtl/seq_tx_1011.sv
// Serial "1011" frame transmitter: preamble 1011 then a W-bit payload MSB
// first, with 0-stuffing so the preamble never reappears inside the frame.
module seq_tx_1011
  import seq_1011_pkg::*;
#(
  parameter int W   = 8,
  parameter int DIV = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [W-1:0] data_in,
  output logic         tx,
  output logic         busy,
  output logic         done
);

  localparam int RW = $clog2(W + 1);

  tx_state_t     state_reg;
  logic [W-1:0]  shift_reg;
  logic [RW-1:0] rem_reg;
  logic [1:0]    pre_idx_reg;
  logic [2:0]    pre_sr_reg;
  logic [2:0]    hist_reg;
  logic          tx_reg;
  logic          busy_reg;
  logic          done_reg;

  logic          timer_en;
  logic          bit_tick;
  logic          stuff_now;
  logic          data_bit;

  assign timer_en  = (state_reg == ST_PRE) || (state_reg == ST_DATA);
  // Stuff decision looks at the three bits already on the line.
  assign stuff_now = (hist_reg == STUFF_TRIGGER);
  assign data_bit  = stuff_now ? 1'b0 : shift_reg[W-1];

  seq_bit_timer #(
    .DIV (DIV)
  ) u_bit_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (timer_en),
    .bit_tick (bit_tick)
  );

  // Frame FSM: every register update changes the line bit, the history and
  // the payload bookkeeping together on a bit-period boundary.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= ST_IDLE;
      shift_reg   <= '0;
      rem_reg     <= '0;
      pre_idx_reg <= '0;
      pre_sr_reg  <= '0;
      hist_reg    <= '0;
      tx_reg      <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          tx_reg   <= 1'b0;
          busy_reg <= 1'b0;
          done_reg <= 1'b0;
          if (start) begin
            shift_reg   <= data_in;
            rem_reg     <= RW'(W);
            pre_idx_reg <= '0;
            pre_sr_reg  <= PREAMBLE[2:0];
            hist_reg    <= hist_push(3'b000, PREAMBLE[3]);
            tx_reg      <= PREAMBLE[3];
            busy_reg    <= 1'b1;
            state_reg   <= ST_PRE;
          end
        end

        ST_PRE: begin
          if (bit_tick) begin
            if (pre_idx_reg == 2'd3) begin
              // First payload bit; history is 011 here so it is never stuffed.
              tx_reg    <= data_bit;
              hist_reg  <= hist_push(hist_reg, data_bit);
              if (!stuff_now) begin
                shift_reg <= shift_reg << 1;
                rem_reg   <= rem_reg - 1'b1;
              end
              state_reg <= ST_DATA;
            end else begin
              tx_reg      <= pre_sr_reg[2];
              hist_reg    <= hist_push(hist_reg, pre_sr_reg[2]);
              pre_sr_reg  <= pre_sr_reg << 1;
              pre_idx_reg <= pre_idx_reg + 2'd1;
            end
          end
        end

        ST_DATA: begin
          if (bit_tick) begin
            if (rem_reg == '0) begin
              // Last payload bit finished: no trailing stuff bit.
              tx_reg    <= 1'b0;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
              state_reg <= ST_DONE;
            end else begin
              tx_reg   <= data_bit;
              hist_reg <= hist_push(hist_reg, data_bit);
              if (!stuff_now) begin
                shift_reg <= shift_reg << 1;
                rem_reg   <= rem_reg - 1'b1;
              end
            end
          end
        end

        ST_DONE: begin
          tx_reg    <= 1'b0;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
          hist_reg  <= '0;
          state_reg <= ST_IDLE;
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx   = tx_reg;
  assign busy = busy_reg;
  assign done = done_reg;

endmodule

// File: tb/tb_seq_tx_1011.sv
// Randomized bench for seq_tx_1011 with a queue-based frame model.
module tb_seq_tx_1011;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start_a, start_b;
  logic [W-1:0] data_a, data_b;
  logic         tx_a, busy_a, done_a;
  logic         tx_b, busy_b, done_b;

  int n_vec = 0;
  int n_err = 0;

  bit exp_q[$];
  bit obs_q[$];

  always #5 clk = ~clk;

  seq_tx_1011 #(.W(W), .DIV(1)) u_dut_d1 (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start_a),
    .data_in (data_a),
    .tx      (tx_a),
    .busy    (busy_a),
    .done    (done_a)
  );

  seq_tx_1011 #(.W(W), .DIV(3)) u_dut_d3 (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start_b),
    .data_in (data_b),
    .tx      (tx_b),
    .busy    (busy_b),
    .done    (done_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Expected line bits: preamble, then payload MSB first, inserting a 0
  // whenever the last three line bits read 1,0,1 and payload remains.
  task automatic model_frame(input logic [W-1:0] d);
    int i;
    int n;
    exp_q.delete();
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b1);
    i = W - 1;
    while (i >= 0) begin
      n = exp_q.size();
      if (exp_q[n-3] == 1'b1 && exp_q[n-2] == 1'b0 && exp_q[n-1] == 1'b1) begin
        exp_q.push_back(1'b0);
      end else begin
        exp_q.push_back(d[i]);
        i--;
      end
    end
  endtask

  function automatic logic [2:0] outs(input bit sel);
    return sel ? {tx_b, busy_b, done_b} : {tx_a, busy_a, done_a};
  endfunction

  task automatic drive_start(input bit sel, input logic v, input logic [W-1:0] d);
    if (sel) begin
      start_b = v;
      data_b  = d;
    end else begin
      start_a = v;
      data_a  = d;
    end
  endtask

  // One frame: start, check {tx,busy,done} every cycle, check done pulse and
  // that 1011 shows up on the line only at offset 0.
  task automatic run_frame(input bit sel, input logic [W-1:0] d, input int repulse_at,
                           input bit start_in_done, input logic [W-1:0] next_d);
    int div;
    int cnt;
    int first;
    logic [2:0] o;
    div = sel ? 3 : 1;
    model_frame(d);
    obs_q.delete();
    drive_start(sel, 1'b1, d);
    @(posedge clk);
    #1 drive_start(sel, 1'b0, W'($urandom));
    for (int k = 0; k < exp_q.size(); k++) begin
      for (int j = 0; j < div; j++) begin
        @(negedge clk);
        o = outs(sel);
        chk($sformatf("d%0d_%02h_bit%0d_c%0d", div, d, k, j), 32'(o), 32'({exp_q[k], 1'b1, 1'b0}));
        if (j == 0) obs_q.push_back(o[2]);
        if (k == repulse_at && j == 0) drive_start(sel, 1'b1, ~d);
        else drive_start(sel, 1'b0, W'($urandom));
      end
    end
    @(negedge clk);
    chk($sformatf("d%0d_%02h_done", div, d), 32'(outs(sel)), 32'(3'b001));
    cnt = 0;
    first = -1;
    for (int i = 0; i + 3 < obs_q.size(); i++) begin
      if (obs_q[i] && !obs_q[i+1] && obs_q[i+2] && obs_q[i+3]) begin
        cnt++;
        if (first < 0) first = i;
      end
    end
    chk($sformatf("d%0d_%02h_pat_cnt", div, d), 32'(cnt), 32'd1);
    chk($sformatf("d%0d_%02h_pat_pos", div, d), 32'(first), 32'd0);
    if (start_in_done) drive_start(sel, 1'b1, next_d);
    else drive_start(sel, 1'b0, W'($urandom));
  endtask

  task automatic idle_check(input bit sel, input int n, input string tag);
    repeat (n) begin
      @(negedge clk);
      chk(tag, 32'(outs(sel)), 32'd0);
    end
  endtask

  initial begin
    bit           sel;
    bit           chain;
    int           rp;
    logic [W-1:0] d;
    logic [W-1:0] nd;

    reset_n = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    data_a  = '0;
    data_b  = '0;
    #12;
    chk("reset_a", 32'(outs(1'b0)), 32'd0);
    chk("reset_b", 32'(outs(1'b1)), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    idle_check(1'b0, 2, "idle_a");
    idle_check(1'b1, 1, "idle_b");

    // Directed frames, back to back with a single idle cycle between them.
    run_frame(1'b0, 8'hFF, -1, 1'b0, '0);
    idle_check(1'b0, 1, "gap_ff");
    run_frame(1'b0, 8'hA5, -1, 1'b0, '0);
    idle_check(1'b0, 1, "gap_a5");
    run_frame(1'b0, 8'hB6, 6, 1'b0, '0);
    idle_check(1'b0, 1, "gap_b6");
    // start held high through DONE: ignored there, accepted one cycle later.
    run_frame(1'b0, 8'h3C, 2, 1'b1, 8'hC3);
    idle_check(1'b0, 1, "done_ignore");
    run_frame(1'b0, 8'hC3, -1, 1'b0, '0);
    idle_check(1'b0, 1, "gap_c3");

    // Reset mid-frame while the line is driving a 1.
    drive_start(1'b0, 1'b1, 8'hFF);
    @(posedge clk);
    #1 drive_start(1'b0, 1'b0, '0);
    repeat (8) @(negedge clk);
    chk("pre_rst_busy", 32'(outs(1'b0)), 32'(3'b110));
    #2 reset_n = 1'b0;
    #1 chk("rst_async", 32'(outs(1'b0)), 32'd0);
    @(negedge clk);
    chk("rst_hold", 32'(outs(1'b0)), 32'd0);
    reset_n = 1'b1;
    idle_check(1'b0, 2, "post_rst");
    run_frame(1'b0, 8'h00, -1, 1'b0, '0);
    idle_check(1'b0, 1, "gap_00");

    // Slow line.
    run_frame(1'b1, 8'h0F, -1, 1'b0, '0);
    idle_check(1'b1, 1, "gap_0f");

    // Random frames on both instances.
    for (int it = 0; it < 24; it++) begin
      sel   = ($urandom_range(0, 3) == 0);
      d     = W'($urandom);
      nd    = W'($urandom);
      chain = $urandom_range(0, 1) == 1;
      rp    = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 11)) : -1;
      run_frame(sel, d, rp, chain, nd);
      idle_check(sel, 1, "rnd_gap");
      if (chain) begin
        run_frame(sel, nd, -1, 1'b0, '0);
        idle_check(sel, 1, "rnd_gap2");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
